// File: rtl/pipa_pulse_source.sv
// Bench-side PIPA responder: holds a signed velocity backlog per axis and, on each
// PIPSAM sample, drives one ternary active-low pulse per axis for PULSE_CYC clocks.
module pipa_pulse_source #(
   parameter int CNT_W     = 16,
   parameter int PULSE_CYC = 8
) (
   input  logic             CLOCK,
   input  logic             rst_,
   input  logic             PIPSAM,
   input  logic             ld,
   input  logic [1:0]       ld_axis,
   input  logic [CNT_W-1:0] ld_val,
   input  logic [2:0]       fail_inj,
   output logic             PIPAXp_,
   output logic             PIPAXm_,
   output logic             PIPAYp_,
   output logic             PIPAYm_,
   output logic             PIPAZp_,
   output logic             PIPAZm_,
   output logic             busy,
   output logic             ovf,
   output logic             missed,
   output logic [CNT_W-1:0] pend_x,
   output logic [CNT_W-1:0] pend_y,
   output logic [CNT_W-1:0] pend_z
);

   localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
   localparam int EW = CNT_W + 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECIDE = 2'd1,
      DRIVE  = 2'd2
   } state_t;

   // One combined update old + adj + (optional) add_v with a single saturation;
   // bit CNT_W of the result flags that the value was clamped.
   function automatic logic [CNT_W:0] sat_step(
      input logic [CNT_W-1:0] old_v,
      input logic [1:0]       adj,
      input logic             add_en,
      input logic [CNT_W-1:0] add_v
   );
      logic signed [EW-1:0] sum;
      logic signed [EW-1:0] max_v;
      logic signed [EW-1:0] min_v;
      logic signed [EW-1:0] add_x;
      logic signed [EW-1:0] old_x;
      logic signed [EW-1:0] adj_x;
      max_v = {3'b000, {(CNT_W-1){1'b1}}};
      min_v = {3'b111, {(CNT_W-1){1'b0}}};
      old_x = {{2{old_v[CNT_W-1]}}, old_v};
      adj_x = {{CNT_W{adj[1]}}, adj};
      if (add_en) begin
         add_x = {{2{add_v[CNT_W-1]}}, add_v};
      end else begin
         add_x = {EW{1'b0}};
      end
      sum = old_x + adj_x + add_x;
      if (sum > max_v) begin
         sat_step = {1'b1, max_v[CNT_W-1:0]};
      end else if (sum < min_v) begin
         sat_step = {1'b1, min_v[CNT_W-1:0]};
      end else begin
         sat_step = {1'b0, sum[CNT_W-1:0]};
      end
   endfunction

   logic             sync1_r;
   logic             sync2_r;
   logic             sync3_r;
   logic             edge_s;
   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [2:0]       line_p_r;
   logic [2:0]       line_m_r;
   logic             busy_r;
   logic             ovf_r;
   logic             missed_r;
   logic [CNT_W-1:0] pend_r [3];
   logic [2:0]       plus_s;
   logic [2:0]       minus_s;
   logic [2:0]       hit_s;
   logic [2:0]       sat_s;
   logic [1:0]       adj_s  [3];
   logic [CNT_W:0]   step_s [3];

   assign edge_s = sync2_r & ~sync3_r;

   // PIPSAM synchronizer plus the delayed copy used for rising-edge detection.
   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
      end else begin
         sync1_r <= PIPSAM;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   // Per-axis direction choice and next backlog value (DECIDE step merged with load).
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         minus_s[i] = pend_r[i][CNT_W-1];
         plus_s[i]  = ~pend_r[i][CNT_W-1] & (|pend_r[i]);
         hit_s[i]   = ld & (ld_axis == 2'(i));
         if ((state_r == DECIDE) && !fail_inj[i] && plus_s[i]) begin
            adj_s[i] = 2'b11;
         end else if ((state_r == DECIDE) && !fail_inj[i] && minus_s[i]) begin
            adj_s[i] = 2'b01;
         end else begin
            adj_s[i] = 2'b00;
         end
         step_s[i] = sat_step(pend_r[i], adj_s[i], hit_s[i], ld_val);
         sat_s[i]  = hit_s[i] & step_s[i][CNT_W];
      end
   end

   // Backlog registers and the sticky overflow flag.
   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_) begin
         for (int i = 0; i < 3; i++) begin
            pend_r[i] <= {CNT_W{1'b0}};
         end
         ovf_r <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            pend_r[i] <= step_s[i][CNT_W-1:0];
         end
         ovf_r <= ovf_r | (|sat_s);
      end
   end

   // Sample FSM: pulse lines, busy and the sticky missed-edge flag.
   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_) begin
         state_r  <= IDLE;
         cnt_r    <= {CW{1'b0}};
         line_p_r <= 3'b111;
         line_m_r <= 3'b111;
         busy_r   <= 1'b0;
         missed_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (edge_s) begin
                  state_r <= DECIDE;
                  busy_r  <= 1'b1;
               end
            end
            DECIDE: begin
               if (edge_s) begin
                  missed_r <= 1'b1;
               end
               for (int i = 0; i < 3; i++) begin
                  if (fail_inj[i]) begin
                     line_p_r[i] <= 1'b0;
                     line_m_r[i] <= 1'b0;
                  end else begin
                     line_p_r[i] <= ~plus_s[i];
                     line_m_r[i] <= ~minus_s[i];
                  end
               end
               cnt_r   <= {CW{1'b0}};
               state_r <= DRIVE;
            end
            DRIVE: begin
               if (edge_s) begin
                  missed_r <= 1'b1;
               end
               if (cnt_r == CW'(PULSE_CYC - 1)) begin
                  line_p_r <= 3'b111;
                  line_m_r <= 3'b111;
                  busy_r   <= 1'b0;
                  state_r  <= IDLE;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               line_p_r <= 3'b111;
               line_m_r <= 3'b111;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

   assign PIPAXp_ = line_p_r[0];
   assign PIPAXm_ = line_m_r[0];
   assign PIPAYp_ = line_p_r[1];
   assign PIPAYm_ = line_m_r[1];
   assign PIPAZp_ = line_p_r[2];
   assign PIPAZm_ = line_m_r[2];
   assign busy    = busy_r;
   assign ovf     = ovf_r;
   assign missed  = missed_r;
   assign pend_x  = pend_r[0];
   assign pend_y  = pend_r[1];
   assign pend_z  = pend_r[2];

endmodule

// File: tb/tb_pipa_pulse_source.sv
// Self-checking bench for pipa_pulse_source: a table of loads/samples with a
// scoreboard of expected pulse windows, plus hand-written miss and reset sequences.
module tb_pipa_pulse_source;
   localparam int CNT_W     = 16;
   localparam int PULSE_CYC = 8;

   logic             CLOCK = 1'b0;
   logic             rst_ = 1'b0;
   logic             PIPSAM = 1'b0;
   logic             ld = 1'b0;
   logic [1:0]       ld_axis = 2'd0;
   logic [CNT_W-1:0] ld_val = 16'd0;
   logic [2:0]       fail_inj = 3'd0;
   logic             PIPAXp_, PIPAXm_, PIPAYp_, PIPAYm_, PIPAZp_, PIPAZm_;
   logic             busy, ovf, missed;
   logic [CNT_W-1:0] pend_x, pend_y, pend_z;
   logic [5:0]       lines_s;

   pipa_pulse_source #(.CNT_W(CNT_W), .PULSE_CYC(PULSE_CYC)) dut (
      .CLOCK(CLOCK), .rst_(rst_), .PIPSAM(PIPSAM), .ld(ld), .ld_axis(ld_axis),
      .ld_val(ld_val), .fail_inj(fail_inj),
      .PIPAXp_(PIPAXp_), .PIPAXm_(PIPAXm_), .PIPAYp_(PIPAYp_), .PIPAYm_(PIPAYm_),
      .PIPAZp_(PIPAZp_), .PIPAZm_(PIPAZm_), .busy(busy), .ovf(ovf), .missed(missed),
      .pend_x(pend_x), .pend_y(pend_y), .pend_z(pend_z)
   );

   assign lines_s = {PIPAZm_, PIPAZp_, PIPAYm_, PIPAYp_, PIPAXm_, PIPAXp_};

   always #5 CLOCK = ~CLOCK;

   typedef enum logic [1:0] {OP_LOAD, OP_SAMPLE, OP_LDDEC, OP_RESET} op_t;

   typedef struct {
      op_t         op;
      logic [1:0]  axis;
      logic [15:0] val;
      logic [2:0]  fail;
      logic [5:0]  lines;
      logic [15:0] px;
      logic [15:0] py;
      logic [15:0] pz;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [5:0]  lines;
      logic [15:0] px;
      logic [15:0] py;
      logic [15:0] pz;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   win_seen = 0;
   int   win_pushed = 0;
   bit   mon_en = 1'b1;

   function automatic vec_t mk(input op_t op, input logic [1:0] ax, input logic [15:0] v,
                               input logic [2:0] f, input logic [5:0] ln,
                               input logic [15:0] px, input logic [15:0] py,
                               input logic [15:0] pz, input logic ov);
      vec_t r;
      r.op = op; r.axis = ax; r.val = v; r.fail = f; r.lines = ln;
      r.px = px; r.py = py; r.pz = pz; r.ovf = ov;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   // Scoreboard consumer: captures each busy window and compares it to the queue head.
   initial begin : monitor
      logic       busy_prev;
      logic [5:0] pat;
      int         width;
      bit         unstable;
      exp_t       e;
      busy_prev = 1'b0;
      forever begin
         tick();
         if (mon_en && rst_ && busy && !busy_prev) begin
            tick();
            pat = lines_s;
            width = 1;
            unstable = 1'b0;
            while (busy && width < PULSE_CYC + 4) begin
               tick();
               if (busy) begin
                  width++;
                  if (lines_s !== pat) unstable = 1'b1;
               end
            end
            win_seen++;
            chk("sb_window_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("pulse_lines", 32'(pat), 32'(e.lines));
               chk("pulse_width", 32'(width), 32'(PULSE_CYC));
               chk("pulse_stable", 32'(unstable), 32'd0);
               chk("lines_idle_after", 32'(lines_s), 32'h3F);
               chk("pend_x_after", 32'(pend_x), 32'(e.px));
               chk("pend_y_after", 32'(pend_y), 32'(e.py));
               chk("pend_z_after", 32'(pend_z), 32'(e.pz));
            end
         end
         busy_prev = busy;
      end
   end

   task automatic do_load(input logic [1:0] ax, input logic [15:0] v);
      ld = 1'b1; ld_axis = ax; ld_val = v;
      tick();
      ld = 1'b0;
   endtask

   task automatic do_sample(input logic [2:0] f, input bit dec_ld, input logic [1:0] ax,
                            input logic [15:0] v, input exp_t e);
      int lat;
      int n;
      exp_q.push_back(e);
      win_pushed++;
      fail_inj = f;
      PIPSAM = 1'b1;
      lat = 0;
      while (!busy && lat < 10) begin
         tick();
         lat++;
      end
      chk("sample_latency", 32'(lat), 32'd3);
      PIPSAM = 1'b0;
      if (dec_ld) begin
         do_load(ax, v);
      end
      n = 0;
      while (busy && n < PULSE_CYC + 8) begin
         tick();
         n++;
      end
      chk("busy_released", 32'(busy), 32'd0);
      tick();
      tick();
      fail_inj = 3'd0;
   endtask

   task automatic do_reset();
      rst_ = 1'b0;
      tick();
      tick();
      rst_ = 1'b1;
      tick();
   endtask

   initial begin : main
      exp_t e;
      int   n;
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(OP_SAMPLE, 2'd0, 16'd0, 3'd0, 6'b111111, 16'd0, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_LOAD,   2'd0, 16'd3,    3'd0, 6'b111111, 16'd3, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_LOAD,   2'd1, 16'hFFFE, 3'd0, 6'b111111, 16'd3, 16'hFFFE, 16'd0, 1'b0));
      vecs.push_back(mk(OP_SAMPLE, 2'd0, 16'd0, 3'd0, 6'b110110, 16'd2, 16'hFFFF, 16'd0, 1'b0));
      vecs.push_back(mk(OP_SAMPLE, 2'd0, 16'd0, 3'd0, 6'b110110, 16'd1, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_SAMPLE, 2'd0, 16'd0, 3'd0, 6'b111110, 16'd0, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_SAMPLE, 2'd0, 16'd0, 3'd0, 6'b111111, 16'd0, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_LOAD,   2'd3, 16'd100,  3'd0, 6'b111111, 16'd0, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_LOAD,   2'd0, 16'h7FFF, 3'd0, 6'b111111, 16'h7FFF, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_LOAD,   2'd0, 16'd5,    3'd0, 6'b111111, 16'h7FFF, 16'd0, 16'd0, 1'b1));
      vecs.push_back(mk(OP_LOAD,   2'd2, 16'h8000, 3'd0, 6'b111111, 16'h7FFF, 16'd0, 16'h8000, 1'b1));
      vecs.push_back(mk(OP_LOAD,   2'd2, 16'hFFFF, 3'd0, 6'b111111, 16'h7FFF, 16'd0, 16'h8000, 1'b1));
      vecs.push_back(mk(OP_RESET,  2'd0, 16'd0,    3'd0, 6'b111111, 16'd0, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_LOAD,   2'd0, 16'd4,    3'd0, 6'b111111, 16'd4, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_SAMPLE, 2'd0, 16'd0, 3'b001, 6'b111100, 16'd4, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_SAMPLE, 2'd0, 16'd0, 3'd0, 6'b111110, 16'd3, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(OP_LDDEC,  2'd1, 16'd1,    3'd0, 6'b111110, 16'd2, 16'd1, 16'd0, 1'b0));
      vecs.push_back(mk(OP_LDDEC,  2'd1, 16'hFFFF, 3'd0, 6'b111010, 16'd1, 16'hFFFF, 16'd0, 1'b0));

      // Reset state, observed while reset is still asserted.
      tick();
      tick();
      chk("rst_lines", 32'(lines_s), 32'h3F);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_missed", 32'(missed), 32'd0);
      chk("rst_pend", 32'({pend_x, pend_y} | 32'(pend_z)), 32'd0);
      rst_ = 1'b1;
      tick();

      foreach (vecs[i]) begin
         e.lines = vecs[i].lines; e.px = vecs[i].px; e.py = vecs[i].py; e.pz = vecs[i].pz;
         case (vecs[i].op)
            OP_LOAD, OP_RESET: begin
               if (vecs[i].op == OP_LOAD) do_load(vecs[i].axis, vecs[i].val);
               else do_reset();
               chk($sformatf("v%0d_pend_x", i), 32'(pend_x), 32'(vecs[i].px));
               chk($sformatf("v%0d_pend_y", i), 32'(pend_y), 32'(vecs[i].py));
               chk($sformatf("v%0d_pend_z", i), 32'(pend_z), 32'(vecs[i].pz));
               chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            end
            OP_SAMPLE: do_sample(vecs[i].fail, 1'b0, 2'd0, 16'd0, e);
            default:   do_sample(vecs[i].fail, 1'b1, vecs[i].axis, vecs[i].val, e);
         endcase
      end

      // Second PIPSAM edge a few cycles into DRIVE: dropped and flagged.
      chk("missed_clear_before", 32'(missed), 32'd0);
      e.lines = 6'b110110; e.px = 16'd0; e.py = 16'd0; e.pz = 16'd0;
      exp_q.push_back(e);
      win_pushed++;
      PIPSAM = 1'b1;
      n = 0;
      while (!busy && n < 10) begin tick(); n++; end
      chk("miss_first_busy", 32'(busy), 32'd1);
      PIPSAM = 1'b0;
      repeat (4) tick();
      PIPSAM = 1'b1;
      repeat (3) tick();
      PIPSAM = 1'b0;
      n = 0;
      while (busy && n < PULSE_CYC + 8) begin tick(); n++; end
      repeat (6) tick();
      chk("missed_set", 32'(missed), 32'd1);
      chk("miss_no_second_pulse", 32'(busy), 32'd0);

      // Reset asserted mid-DRIVE: lines release asynchronously, state clears.
      mon_en = 1'b0;
      do_load(2'd0, 16'd2);
      do_load(2'd1, 16'hFFFD);
      PIPSAM = 1'b1;
      n = 0;
      while (!busy && n < 10) begin tick(); n++; end
      PIPSAM = 1'b0;
      repeat (3) tick();
      chk("middrive_lines", 32'(lines_s), 32'h36);
      chk("middrive_pend_y", 32'(pend_y), 32'hFFFE);
      @(posedge CLOCK);
      #3;
      rst_ = 1'b0;
      #1;
      chk("async_rst_lines", 32'(lines_s), 32'h3F);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_pend_x", 32'(pend_x), 32'd0);
      chk("async_rst_pend_y", 32'(pend_y), 32'd0);
      chk("async_rst_missed", 32'(missed), 32'd0);
      tick();
      rst_ = 1'b1;
      repeat (PULSE_CYC + 2) tick();
      chk("post_rst_lines", 32'(lines_s), 32'h3F);
      chk("post_rst_busy", 32'(busy), 32'd0);
      mon_en = 1'b1;

      chk("windows_seen", 32'(win_seen), 32'(win_pushed));
      chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
